// File: rtl/save_state_if.sv
// save_state_if: scheduler/RAM-side bundle for the save stage (context in, RAM port and status out)
interface save_state_if #(
    parameter int addrBits = 8,
    parameter int dataBits = 16
);
    logic                start;
    logic [addrBits-1:0] stackPointer;
    logic [addrBits-1:0] callStackPointer;
    logic [8:0]          programCounter;
    logic [3:0]          aluFlags;
    logic [addrBits-1:0] address;
    logic [dataBits-1:0] dataIn;
    logic                rwMode;
    logic                busy;
    logic                finished;
    modport master (
        output start, stackPointer, callStackPointer, programCounter, aluFlags,
        input  address, dataIn, rwMode, busy, finished
    );
    modport slave (
        input  start, stackPointer, callStackPointer, programCounter, aluFlags,
        output address, dataIn, rwMode, busy, finished
    );
endinterface

// File: rtl/save_state.sv
// save_state: writes the captured process context as a two-word record at RAM addresses 0 and 1
module save_state #(
    parameter int addrBits = 8,
    parameter int dataBits = 16
) (
    input logic         clk,
    input logic         reset,
    save_state_if.slave bus
);
    localparam logic RAM_READ  = 1'b0;
    localparam logic RAM_WRITE = 1'b1;
    typedef enum logic [2:0] {IDLE, SP_SETUP, SP_WRITE, PC_SETUP, PC_WRITE, DONE} state_t;
    state_t      r_state, w_next;
    logic [7:0]  r_sp, r_csp;
    logic [8:0]  r_pc;
    logic [3:0]  r_flags;
    logic        w_accept;
    logic [15:0] w_word0, w_word1;
    always_comb begin
        w_accept = (r_state == IDLE || r_state == DONE) && bus.start;
        w_next = r_state;
        case (r_state)
            IDLE, DONE: w_next = w_accept ? SP_SETUP : r_state;
            SP_SETUP:   w_next = SP_WRITE;
            SP_WRITE:   w_next = PC_SETUP;
            PC_SETUP:   w_next = PC_WRITE;
            PC_WRITE:   w_next = DONE;
            default:    w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_sp    <= '0;
            r_csp   <= '0;
            r_pc    <= '0;
            r_flags <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_sp    <= bus.stackPointer[7:0];
                r_csp   <= bus.callStackPointer[7:0];
                r_pc    <= bus.programCounter;
                r_flags <= bus.aluFlags;
            end
        end
    end
    // CSP is stored minus 2 because the resume stage adds 2 back
    assign w_word0      = {r_sp, r_csp - 8'd2};
    assign w_word1      = {r_flags, 3'b000, r_pc};
    assign bus.busy     = r_state inside {SP_SETUP, SP_WRITE, PC_SETUP, PC_WRITE};
    assign bus.finished = r_state == DONE;
    assign bus.rwMode   = (r_state == SP_WRITE || r_state == PC_WRITE) ? RAM_WRITE : RAM_READ;
    assign bus.address  = (r_state == PC_SETUP || r_state == PC_WRITE) ? addrBits'(1) : '0;
    assign bus.dataIn   = (r_state == SP_SETUP || r_state == SP_WRITE) ? dataBits'(w_word0) :
                          (r_state == PC_SETUP || r_state == PC_WRITE) ? dataBits'(w_word1) : '0;
endmodule

// File: tb/tb_save_state.sv
// tb_save_state: vector-table and directed checks of save_state against a RAM/resume model
module tb_save_state;
    localparam logic RAM_READ  = 1'b0;
    localparam logic RAM_WRITE = 1'b1;
    typedef struct {
        logic [7:0]  sp, csp;
        logic [8:0]  pc;
        logic [3:0]  fl;
        logic [15:0] w0, w1;
    } vec_t;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    save_state_if bus();
    save_state dut (.clk(clk), .reset(reset), .bus(bus));
    int n_checks = 0;
    int n_errors = 0;
    int wc = 0;
    logic [15:0] ram [0:255];
    vec_t vecs [4];
    always @(posedge clk) begin
        if (bus.rwMode === RAM_WRITE) begin
            ram[bus.address] <= bus.dataIn;
            wc <= wc + 1;
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic resume_check(input logic [7:0] sp, input logic [7:0] csp, input logic [8:0] pc, input logic [3:0] fl);
        chk("rt_sp", 32'(ram[0][15:8]), 32'(sp));
        chk("rt_csp", 32'(8'(ram[0][7:0] + 8'd2)), 32'(csp));
        chk("rt_pc", 32'(ram[1][8:0]), 32'(pc));
        chk("rt_flags", 32'(ram[1][15:12]), 32'(fl));
        chk("rt_zero", 32'(ram[1][11:9]), 32'd0);
    endtask
    task automatic run_save(input logic [7:0] sp, input logic [7:0] csp, input logic [8:0] pc,
                            input logic [3:0] fl, input logic [15:0] w0, input logic [15:0] w1,
                            input int busy_start, input bit hold);
        int base;
        bus.stackPointer = sp;
        bus.callStackPointer = csp;
        bus.programCounter = pc;
        bus.aluFlags = fl;
        bus.start = 1'b1;
        base = wc;
        tick();
        for (int c = 1; c <= 4; c++) begin
            bus.start = hold || c == busy_start;
            bus.stackPointer = ~sp;
            bus.callStackPointer = sp ^ 8'h5A;
            bus.programCounter = ~pc;
            bus.aluFlags = ~fl;
            chk("busy", 32'(bus.busy), 32'd1);
            chk("finished_low", 32'(bus.finished), 32'd0);
            chk("rwMode", 32'(bus.rwMode), (c == 2 || c == 4) ? 32'(RAM_WRITE) : 32'(RAM_READ));
            chk("address", 32'(bus.address), c < 3 ? 32'd0 : 32'd1);
            chk("dataIn", 32'(bus.dataIn), c < 3 ? 32'(w0) : 32'(w1));
            tick();
        end
        bus.start = hold;
        chk("finished", 32'(bus.finished), 32'd1);
        chk("busy_done", 32'(bus.busy), 32'd0);
        chk("rw_done", 32'(bus.rwMode), 32'(RAM_READ));
        chk("addr_done", 32'(bus.address), 32'd0);
        chk("data_done", 32'(bus.dataIn), 32'd0);
        chk("write_count", 32'(wc - base), 32'd2);
    endtask
    initial begin
        int base;
        logic [7:0] sp, csp;
        logic [8:0] pc;
        logic [3:0] fl;
        bus.start = 1'b0;
        bus.stackPointer = '0;
        bus.callStackPointer = '0;
        bus.programCounter = '0;
        bus.aluFlags = '0;
        vecs[0] = '{sp: 8'h40, csp: 8'hA2, pc: 9'h1F3, fl: 4'b1010, w0: 16'h40A0, w1: 16'hA1F3};
        vecs[1] = '{sp: 8'h12, csp: 8'h00, pc: 9'h000, fl: 4'b0000, w0: 16'h12FE, w1: 16'h0000};
        vecs[2] = '{sp: 8'hFF, csp: 8'h01, pc: 9'h1FF, fl: 4'b1111, w0: 16'hFFFF, w1: 16'hF1FF};
        vecs[3] = '{sp: 8'h00, csp: 8'h02, pc: 9'h100, fl: 4'b0101, w0: 16'h0000, w1: 16'h5100};
        tick();
        tick();
        chk("rst_address", 32'(bus.address), 32'd0);
        chk("rst_dataIn", 32'(bus.dataIn), 32'd0);
        chk("rst_rwMode", 32'(bus.rwMode), 32'(RAM_READ));
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_finished", 32'(bus.finished), 32'd0);
        reset = 1'b1;
        tick();
        chk("idle_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            run_save(vecs[i].sp, vecs[i].csp, vecs[i].pc, vecs[i].fl, vecs[i].w0, vecs[i].w1, 0, 1'b0);
            resume_check(vecs[i].sp, vecs[i].csp, vecs[i].pc, vecs[i].fl);
        end
        run_save(vecs[0].sp, vecs[0].csp, vecs[0].pc, vecs[0].fl, vecs[0].w0, vecs[0].w1, 2, 1'b0);
        tick();
        chk("done_holds", 32'(bus.finished), 32'd1);
        chk("done_addr", 32'(bus.address), 32'd0);
        run_save(vecs[1].sp, vecs[1].csp, vecs[1].pc, vecs[1].fl, vecs[1].w0, vecs[1].w1, 0, 1'b1);
        run_save(vecs[2].sp, vecs[2].csp, vecs[2].pc, vecs[2].fl, vecs[2].w0, vecs[2].w1, 0, 1'b0);
        resume_check(vecs[2].sp, vecs[2].csp, vecs[2].pc, vecs[2].fl);
        bus.stackPointer = vecs[0].sp;
        bus.callStackPointer = vecs[0].csp;
        bus.programCounter = vecs[0].pc;
        bus.aluFlags = vecs[0].fl;
        bus.start = 1'b1;
        base = wc;
        tick();
        bus.start = 1'b0;
        tick();
        chk("mid_rw_write", 32'(bus.rwMode), 32'(RAM_WRITE));
        reset = 1'b0;
        tick();
        chk("abort_rw", 32'(bus.rwMode), 32'(RAM_READ));
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_finished", 32'(bus.finished), 32'd0);
        chk("abort_address", 32'(bus.address), 32'd0);
        reset = 1'b1;
        tick();
        tick();
        chk("abort_writes", 32'(wc - base), 32'd1);
        chk("abort_idle", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        bus.start = 1'b1;
        tick();
        chk("reset_wins_busy", 32'(bus.busy), 32'd0);
        chk("reset_wins_data", 32'(bus.dataIn), 32'd0);
        reset = 1'b1;
        bus.start = 1'b0;
        tick();
        chk("post_reset_idle", 32'(bus.busy), 32'd0);
        for (int n = 0; n < 100; n++) begin
            sp = 8'($urandom);
            csp = 8'($urandom);
            pc = 9'($urandom);
            fl = 4'($urandom);
            run_save(sp, csp, pc, fl, {sp, 8'(csp - 8'd2)}, {fl, 3'b000, pc}, 0, 1'b0);
            resume_check(sp, csp, pc, fl);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
